row_driver_seq: RTL
===================

ROW_DRIVER_SEQ -- requirements
Module: row_driver_seq

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of word-line rows, legal range 2..64.
REQ-002 SHALL have parameter AW, default $clog2(ROWS): row-address width.
REQ-003 SHALL have parameter PRE_CYC, default 1: all-lines-low guard cycles before each pulse, legal range 1..15.
REQ-004 SHALL have parameter PULSE_CYC, default 2: cycles each pulse is held, legal range 1..15.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid, input, 1 bit: request present.
REQ-008 SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-009 SHALL have port mode, input, 2 bits: 0 = CAM search, 1 = MAC write, 2 = MAC read, 3 = MAC sweep-read.
REQ-010 SHALL have port addr, input, AW bits: row address; start row for sweep.
REQ-011 SHALL have port key, input, ROWS bits: CAM search key.
REQ-012 SHALL have port abort, input, 1 bit: cancel the operation in progress.
REQ-013 SHALL have port WL, output, ROWS bits: word lines.
REQ-014 SHALL have port WLB, output, ROWS bits: complementary word lines.
REQ-015 SHALL have port busy, output, 1 bit: operation in progress.
REQ-016 SHALL have port row_idx, output, AW bits: row currently driven.
REQ-017 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port err, output, 1 bit: qualifier valid with done.
REQ-019 SHALL have port aborted, output, 1 bit: qualifier valid with done.

Function
REQ-020 SHALL implement FSM states IDLE, PRE, PULSE and DONE; all outputs SHALL be registered.
REQ-021 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge with req_valid=1 and req_ready=1, and mode/addr/key SHALL be latched at that edge.
REQ-022 SHALL make IDLE->PRE on accept; PRE SHALL last PRE_CYC cycles with WL=WLB=0; PULSE SHALL last PULSE_CYC cycles; PULSE->DONE unless a sweep continues; DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-023 SHALL, in mode 0 during PULSE, drive WL=key and WLB=~key (latched key).
REQ-024 SHALL, in mode 1 during PULSE, drive WL=one-hot(row_idx) and WLB=0.
REQ-025 SHALL, in mode 2 during PULSE, drive WL=0 and WLB=one-hot(row_idx).
REQ-026 SHALL, in mode 3, drive WLB one-hot for rows addr..ROWS-1 in ascending order, each row getting its own PRE+PULSE; after a PULSE with row_idx<ROWS-1, row_idx SHALL increment and the FSM return to PRE; after the row ROWS-1 PULSE, the FSM SHALL go to DONE.
REQ-027 SHALL drive WL=WLB=0 in IDLE, PRE and DONE; WL and WLB SHALL never both have the same bit high.
REQ-028 SHALL, for mode 1/2/3 with addr>=ROWS (non-power-of-2 ROWS), skip PRE/PULSE, go straight to DONE, drive no lines, and set err=1 with done; otherwise err=0.
REQ-029 SHALL, on abort=1 in PRE or PULSE, drive WL=WLB=0 on the next edge and enter DONE with aborted=1; abort SHALL be ignored in IDLE and DONE.
REQ-030 SHALL drive busy=1 in PRE, PULSE and DONE.
REQ-031 SHALL drive row_idx=latched addr during ops, 0 in mode 0, and hold its value in IDLE.
REQ-032 SHALL give single-row latency of 1+PRE_CYC+PULSE_CYC cycles from the accept edge to done, and sweep latency of 1+(ROWS-addr)*(PRE_CYC+PULSE_CYC) cycles.
REQ-033 SHALL use phase counters of 4 bits, compare exactly, and never wrap.

Reset
REQ-034 SHALL, while rst=1, immediately force state IDLE, WL=0, WLB=0, busy=0, done=0, err=0, aborted=0, row_idx=0 and req_ready=0.
REQ-035 SHALL drive req_ready=1 from the first edge after rst falls.
REQ-036 SHALL, on reset mid-pulse, drop lines asynchronously with no done pulse.

Verification
REQ-037 SHALL cover: ROWS=4, PRE=1, PULSE=2, mode 2 addr=2 accepted at edge 0 -> WLB=0100 in cycles 2-3, done at cycle 4, req_ready back at cycle 5.
REQ-038 SHALL cover: mode 0 key=1010 -> WL=1010 and WLB=0101 for 2 cycles, row_idx=0.
REQ-039 SHALL cover: mode 3 addr=1 -> WLB 0010, 0100, 1000 each 2 cycles with 1-cycle zero gaps, done at cycle 10.
REQ-040 SHALL cover: abort in the first PULSE cycle of mode 1 -> lines 0 on the next edge, done=1 and aborted=1 one cycle.
REQ-041 SHALL cover: ROWS=3, mode 2 addr=3 -> no line activity, done=1 and err=1 at cycle 1.
REQ-042 SHALL cover: rst asserted mid-sweep -> WL=WLB=0 and busy=0 immediately, no done; req_ready=1 after release.

Source files
------------

// File: rtl/row_driver_seq.sv
// Word-line driver sequencer: guard (PRE) then pulse phases per row for CAM search,
// MAC write/read and multi-row sweep-read, with abort and address-range error reporting.
module row_driver_seq #(
    parameter int ROWS      = 4,
    parameter int AW        = $clog2(ROWS),
    parameter int PRE_CYC   = 1,
    parameter int PULSE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      mode,
    input  logic [AW-1:0]   addr,
    input  logic [ROWS-1:0] key,
    input  logic            abort,
    output logic [ROWS-1:0] WL,
    output logic [ROWS-1:0] WLB,
    output logic            busy,
    output logic [AW-1:0]   row_idx,
    output logic            done,
    output logic            err,
    output logic            aborted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        PULSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_CAM   = 2'd0;
    localparam logic [1:0] MODE_WRITE = 2'd1;
    localparam logic [1:0] MODE_READ  = 2'd2;
    localparam logic [1:0] MODE_SWEEP = 2'd3;

    state_t          state_r;
    logic [3:0]      cnt_r;
    logic [1:0]      mode_r;
    logic [ROWS-1:0] key_r;

    function automatic logic [ROWS-1:0] onehot(input logic [AW-1:0] idx);
        return ROWS'(1) << idx;
    endfunction

    // Line pattern for the pulse phase, packed as {WL, WLB}; the two halves never overlap.
    function automatic logic [2*ROWS-1:0] pulse_lines(input logic [1:0] m,
                                                      input logic [ROWS-1:0] k,
                                                      input logic [AW-1:0] idx);
        logic [2*ROWS-1:0] v;
        case (m)
            MODE_CAM:   v = {k, ~k};
            MODE_WRITE: v = {onehot(idx), {ROWS{1'b0}}};
            MODE_READ:  v = {{ROWS{1'b0}}, onehot(idx)};
            MODE_SWEEP: v = {{ROWS{1'b0}}, onehot(idx)};
            default:    v = {(2*ROWS){1'b0}};
        endcase
        return v;
    endfunction

    // Sequencer: state, phase counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            mode_r    <= 2'd0;
            key_r     <= {ROWS{1'b0}};
            req_ready <= 1'b0;
            WL        <= {ROWS{1'b0}};
            WLB       <= {ROWS{1'b0}};
            busy      <= 1'b0;
            row_idx   <= {AW{1'b0}};
            done      <= 1'b0;
            err       <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    WL      <= {ROWS{1'b0}};
                    WLB     <= {ROWS{1'b0}};
                    done    <= 1'b0;
                    err     <= 1'b0;
                    aborted <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        mode_r    <= mode;
                        key_r     <= key;
                        cnt_r     <= 4'd0;
                        row_idx   <= (mode == MODE_CAM) ? {AW{1'b0}} : addr;
                        // Out-of-range row (only reachable for non-power-of-2 ROWS).
                        if ((mode != MODE_CAM) && (32'(addr) >= 32'(ROWS))) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            state_r <= PRE;
                        end
                    end else begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                PRE: begin
                    if (abort) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        WL      <= {ROWS{1'b0}};
                        WLB     <= {ROWS{1'b0}};
                    end else if (cnt_r == 4'(PRE_CYC - 1)) begin
                        state_r    <= PULSE;
                        cnt_r      <= 4'd0;
                        {WL, WLB}  <= pulse_lines(mode_r, key_r, row_idx);
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                PULSE: begin
                    if (abort) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        WL      <= {ROWS{1'b0}};
                        WLB     <= {ROWS{1'b0}};
                    end else if (cnt_r == 4'(PULSE_CYC - 1)) begin
                        cnt_r <= 4'd0;
                        WL    <= {ROWS{1'b0}};
                        WLB   <= {ROWS{1'b0}};
                        if ((mode_r == MODE_SWEEP) && (32'(row_idx) < 32'(ROWS - 1))) begin
                            state_r <= PRE;
                            row_idx <= row_idx + AW'(1);
                        end else begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    aborted   <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    WL        <= {ROWS{1'b0}};
                    WLB       <= {ROWS{1'b0}};
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= 4'd0;
                    req_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    aborted   <= 1'b0;
                    WL        <= {ROWS{1'b0}};
                    WLB       <= {ROWS{1'b0}};
                end
            endcase
        end
    end

endmodule
